// File: rtl/kalman_pkg.sv
// rtl/kalman_pkg.sv - shared widths, saturation limits and types for the Kalman ALU chain
package kalman_pkg;

  localparam int DATA_W    = 23;
  localparam int GAIN_W    = 13;
  localparam int GAIN_FRAC = 13;

  typedef logic signed [DATA_W-1:0] data_t;
  typedef logic [GAIN_W-1:0]        gain_t;
  typedef logic [2:0]               step_t;

  localparam data_t SAT_MAX = data_t'((1 << (DATA_W-1)) - 1);
  localparam data_t SAT_MIN = data_t'(-(1 << (DATA_W-1)));

  localparam step_t STEP_LAST = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } alu6_state_t;

endpackage

// File: rtl/kalman_satmac.sv
// rtl/kalman_satmac.sv - combinational acc +/- floor(K*x / 2^GAIN_FRAC) with clamping to data_t
module kalman_satmac
  import kalman_pkg::*;
(
  input  data_t acc,
  input  gain_t k,
  input  data_t x,
  input  logic  sub,
  output data_t res
);

  localparam int PROD_W = DATA_W + GAIN_W + 1;

  logic signed [GAIN_W:0]   k_s;
  logic signed [PROD_W-1:0] prod;
  logic signed [DATA_W:0]   m;
  logic signed [DATA_W:0]   acc_e;
  logic signed [DATA_W:0]   sum;
  logic signed [DATA_W:0]   hi;
  logic signed [DATA_W:0]   lo;

  // gain is an unsigned fraction, so a zero sign bit keeps it non-negative
  assign k_s   = {1'b0, k};
  assign prod  = PROD_W'(k_s) * PROD_W'(x);
  // |K| < 1 keeps the scaled product inside DATA_W+1 bits
  assign m     = (DATA_W+1)'(prod >>> GAIN_FRAC);
  assign acc_e = (DATA_W+1)'(acc);
  assign sum   = sub ? (acc_e - m) : (acc_e + m);
  assign hi    = (DATA_W+1)'(SAT_MAX);
  assign lo    = (DATA_W+1)'(SAT_MIN);

  always_comb begin
    res = data_t'(sum);
    if (sum > hi)
      res = SAT_MAX;
    else if (sum < lo)
      res = SAT_MIN;
  end

endmodule

// File: rtl/kalman_alu6.sv
// rtl/kalman_alu6.sv - Kalman measurement update: state and covariance via one shared saturating MAC
module kalman_alu6
  import kalman_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [GAIN_W-1:0]        K0_in,
  input  logic [GAIN_W-1:0]        K1_in,
  input  logic signed [DATA_W-1:0] y_in,
  input  logic signed [DATA_W-1:0] angle_in,
  input  logic signed [DATA_W-1:0] bias_in,
  input  logic signed [DATA_W-1:0] P00_in,
  input  logic signed [DATA_W-1:0] P01_in,
  input  logic signed [DATA_W-1:0] P10_in,
  input  logic signed [DATA_W-1:0] P11_in,
  output logic signed [DATA_W-1:0] angle_out,
  output logic signed [DATA_W-1:0] bias_out,
  output logic signed [DATA_W-1:0] P00_out,
  output logic signed [DATA_W-1:0] P01_out,
  output logic signed [DATA_W-1:0] P10_out,
  output logic signed [DATA_W-1:0] P11_out,
  output logic                     busy,
  output logic                     done
);

  alu6_state_t state;
  step_t       step;

  gain_t k0_r, k1_r;
  data_t y_r, angle_r, bias_r, p00_r, p01_r, p10_r, p11_r;

  data_t mac_acc, mac_x, mac_res;
  gain_t mac_k;
  logic  mac_sub;

  // every product uses the captured operands, never the partially updated outputs
  always_comb begin
    mac_acc = '0;
    mac_k   = '0;
    mac_x   = '0;
    mac_sub = 1'b0;
    case (step)
      3'd0: begin mac_acc = angle_r; mac_k = k0_r; mac_x = y_r;   mac_sub = 1'b0; end
      3'd1: begin mac_acc = bias_r;  mac_k = k1_r; mac_x = y_r;   mac_sub = 1'b0; end
      3'd2: begin mac_acc = p00_r;   mac_k = k0_r; mac_x = p00_r; mac_sub = 1'b1; end
      3'd3: begin mac_acc = p01_r;   mac_k = k0_r; mac_x = p01_r; mac_sub = 1'b1; end
      3'd4: begin mac_acc = p10_r;   mac_k = k1_r; mac_x = p00_r; mac_sub = 1'b1; end
      3'd5: begin mac_acc = p11_r;   mac_k = k1_r; mac_x = p01_r; mac_sub = 1'b1; end
      default: begin mac_acc = '0; mac_k = '0; mac_x = '0; mac_sub = 1'b0; end
    endcase
  end

  kalman_satmac u_satmac (
    .acc (mac_acc),
    .k   (mac_k),
    .x   (mac_x),
    .sub (mac_sub),
    .res (mac_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      step      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      k0_r      <= '0;
      k1_r      <= '0;
      y_r       <= '0;
      angle_r   <= '0;
      bias_r    <= '0;
      p00_r     <= '0;
      p01_r     <= '0;
      p10_r     <= '0;
      p11_r     <= '0;
      angle_out <= '0;
      bias_out  <= '0;
      P00_out   <= '0;
      P01_out   <= '0;
      P10_out   <= '0;
      P11_out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            k0_r      <= K0_in;
            k1_r      <= K1_in;
            y_r       <= y_in;
            angle_r   <= angle_in;
            bias_r    <= bias_in;
            p00_r     <= P00_in;
            p01_r     <= P01_in;
            p10_r     <= P10_in;
            p11_r     <= P11_in;
            angle_out <= angle_in;
            bias_out  <= bias_in;
            P00_out   <= P00_in;
            P01_out   <= P01_in;
            P10_out   <= P10_in;
            P11_out   <= P11_in;
            step      <= '0;
            busy      <= 1'b1;
            state     <= MUL;
          end
        end
        MUL: begin
          case (step)
            3'd0:    angle_out <= mac_res;
            3'd1:    bias_out  <= mac_res;
            3'd2:    P00_out   <= mac_res;
            3'd3:    P01_out   <= mac_res;
            3'd4:    P10_out   <= mac_res;
            3'd5:    P11_out   <= mac_res;
            default: ;
          endcase
          if (step == STEP_LAST) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            step <= step + step_t'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          step  <= '0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kalman_alu6.sv
// tb/tb_kalman_alu6.sv - randomized self-checking bench for kalman_alu6 against an arithmetic reference model
module tb_kalman_alu6;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [12:0]        K0_in, K1_in;
  logic signed [22:0] y_in, angle_in, bias_in, P00_in, P01_in, P10_in, P11_in;
  logic signed [22:0] angle_out, bias_out, P00_out, P01_out, P10_out, P11_out;
  logic               busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  longint exp_v[6];

  always #5 clk = ~clk;

  kalman_alu6 dut (
    .clk(clk), .rst(rst), .start(start),
    .K0_in(K0_in), .K1_in(K1_in), .y_in(y_in),
    .angle_in(angle_in), .bias_in(bias_in),
    .P00_in(P00_in), .P01_in(P01_in), .P10_in(P10_in), .P11_in(P11_in),
    .angle_out(angle_out), .bias_out(bias_out),
    .P00_out(P00_out), .P01_out(P01_out), .P10_out(P10_out), .P11_out(P11_out),
    .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // floor(k*x / 8192) done with integer division so it does not lean on shifts
  function automatic longint scaled(input longint k, input longint x);
    longint p;
    p = k * x;
    if (p >= 0) return p / 8192;
    return -((-p + 8191) / 8192);
  endfunction

  function automatic longint clamp(input longint v);
    if (v > 4194303)  return 4194303;
    if (v < -4194304) return -4194304;
    return v;
  endfunction

  task automatic model();
    longint k0, k1, y, p00, p01;
    k0 = longint'(K0_in); k1 = longint'(K1_in);
    y = longint'(y_in); p00 = longint'(P00_in); p01 = longint'(P01_in);
    exp_v[0] = clamp(longint'(angle_in) + scaled(k0, y));
    exp_v[1] = clamp(longint'(bias_in)  + scaled(k1, y));
    exp_v[2] = clamp(p00 - scaled(k0, p00));
    exp_v[3] = clamp(p01 - scaled(k0, p01));
    exp_v[4] = clamp(longint'(P10_in) - scaled(k1, p00));
    exp_v[5] = clamp(longint'(P11_in) - scaled(k1, p01));
  endtask

  task automatic set_inputs(input logic [12:0] k0, input logic [12:0] k1, input logic signed [22:0] y,
                            input logic signed [22:0] a, input logic signed [22:0] b,
                            input logic signed [22:0] p00, input logic signed [22:0] p01,
                            input logic signed [22:0] p10, input logic signed [22:0] p11);
    K0_in = k0; K1_in = k1; y_in = y; angle_in = a; bias_in = b;
    P00_in = p00; P01_in = p01; P10_in = p10; P11_in = p11;
  endtask

  task automatic scramble();
    K0_in = 13'($urandom); K1_in = 13'($urandom); y_in = 23'($urandom);
    angle_in = 23'($urandom); bias_in = 23'($urandom);
    P00_in = 23'($urandom); P01_in = 23'($urandom);
    P10_in = 23'($urandom); P11_in = 23'($urandom);
  endtask

  // called at a negedge; returns after the start edge with start dropped
  task automatic launch(input bit hold);
    model();
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) begin
      start = 1'b0;
      scramble();
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (1) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (done === 1'b1) break;
      if (lat >= 20) begin lat = -1; break; end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, " angle"}, angle_out, exp_v[0]);
    check({tag, " bias"},  bias_out,  exp_v[1]);
    check({tag, " P00"},   P00_out,   exp_v[2]);
    check({tag, " P01"},   P01_out,   exp_v[3]);
    check({tag, " P10"},   P10_out,   exp_v[4]);
    check({tag, " P11"},   P11_out,   exp_v[5]);
  endtask

  task automatic run_one(input string tag);
    int lat;
    launch(1'b0);
    wait_done(lat);
    check({tag, " latency"}, lat, 6);
    check_outputs(tag);
    @(negedge clk);
    check({tag, " done pulse"}, done, 0);
    check({tag, " idle busy"}, busy, 0);
  endtask

  initial begin
    int lat, busy_cnt, done_cnt;
    rst = 1'b1; start = 1'b0;
    set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset angle", angle_out, 0);
    check("reset P11", P11_out, 0);
    rst = 1'b0;
    @(negedge clk);

    set_inputs(4096, 2048, 1000, 0, 0, 8000, 400, 400, 100);
    launch(1'b0);
    wait_done(lat);
    check("nominal latency", lat, 6);
    check("nominal angle", angle_out, 500);
    check("nominal bias", bias_out, 250);
    check("nominal P00", P00_out, 4000);
    check("nominal P01", P01_out, 200);
    check("nominal P10", P10_out, -1600);
    check("nominal P11", P11_out, 0);
    @(negedge clk);
    check("output hold angle", angle_out, 500);

    set_inputs(0, 0, 23'sd12345, -23'sd777, 23'sd4000000, -23'sd4194304, 23'sd4194303, 23'sd5, -23'sd9);
    run_one("zero gain");

    set_inputs(8191, 0, 23'sd4194303, 23'sd4194000, 0, 0, 0, 0, 0);
    run_one("sat");
    check("sat clamp value", angle_out, 4194303);

    set_inputs(1, 0, -23'sd1, 0, 0, 0, 0, 0, 0);
    run_one("floor");
    check("floor value", angle_out, -1);

    set_inputs(8191, 8191, -23'sd4194304, -23'sd4194304, -23'sd4194304, -23'sd4194304, -23'sd4194304, 23'sd4194303, 23'sd4194303);
    run_one("neg corner");

    for (int i = 0; i < 40; i++) begin
      scramble();
      if (i % 8 == 0) K0_in = 13'd8191;
      run_one($sformatf("rand%0d", i));
    end

    // start held through MUL and DONE, then still high in the next IDLE cycle
    set_inputs(3000, 5000, -23'sd200000, 23'sd100, -23'sd100, 23'sd300000, -23'sd20000, 23'sd7, 23'sd99);
    model();
    start = 1'b1;
    @(posedge clk); #1;
    busy_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (c < 7) @(posedge clk);
    end
    check("held start busy cycles", busy_cnt, 7);
    check("held start done count", done_cnt, 1);
    check("held start idle busy", busy, 0);
    check_outputs("held");
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    check("restart latency", lat, 6);
    check_outputs("restart");
    @(negedge clk);

    // reset while step 3 is pending
    set_inputs(4096, 4096, 23'sd1000, 23'sd1, 23'sd2, 23'sd3, 23'sd4, 23'sd5, 23'sd6);
    launch(1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre-reset busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset busy", busy, 0);
    check("midreset done", done, 0);
    check("midreset angle", angle_out, 0);
    check("midreset P00", P00_out, 0);
    done_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("midreset no done", done_cnt, 0);

    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst+start busy", busy, 0);
    @(negedge clk);
    check("rst+start stays idle", busy, 0);

    set_inputs(4096, 2048, 1000, 0, 0, 8000, 400, 400, 100);
    run_one("post-reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
